// File: rtl/mem_write_arbiter.sv
// rtl/mem_write_arbiter.sv - round-robin N-client write arbiter feeding the DDR3 controller app interface
// Each write pops one address and two 128-bit data words; a grant issues up to MAX_BURST writes.
module mem_write_arbiter #(
  parameter int          NUM_CLIENTS       = 2,
  parameter int          ADDR_WIDTH        = 29,
  parameter int          SIZE_WIDTH        = 10,
  parameter int          ASIZE_WIDTH       = 8,
  parameter int          MAX_BURST         = 8,
  parameter logic [31:0] WRITE_COUNT_RESET = 32'h0,
  localparam int         GW                = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                               clk_ram,
  input  logic                               rst,
  input  logic                               cal_complete,
  output logic [NUM_CLIENTS-1:0]             data_rd_en,
  input  logic [NUM_CLIENTS*128-1:0]         data_rd_data,
  input  logic [NUM_CLIENTS*SIZE_WIDTH-1:0]  data_rd_size,
  output logic [NUM_CLIENTS-1:0]             addr_rd_en,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]  addr_rd_data,
  input  logic [NUM_CLIENTS*ASIZE_WIDTH-1:0] addr_rd_size,
  output logic [ADDR_WIDTH-1:0]              app_addr,
  output logic [2:0]                         app_cmd,
  output logic                               app_en,
  input  logic                               app_rdy,
  output logic [255:0]                       app_wdf_data,
  output logic                               app_wdf_end,
  output logic [31:0]                        app_wdf_mask,
  output logic                               app_wdf_wren,
  input  logic                               app_wdf_rdy,
  output logic                               app_ref_req,
  output logic                               app_sr_req,
  output logic                               app_zq_req,
  output logic                               busy,
  output logic [GW-1:0]                      grant_id,
  output logic [NUM_CLIENTS*32-1:0]          write_count
);

  typedef enum logic [2:0] {S_IDLE, S_POP0, S_POP1, S_CAPT, S_ISSUE} state_t;

  state_t                   r_state;
  logic [GW-1:0]            r_grant;
  logic [GW-1:0]            r_last;
  logic [7:0]               r_burst;
  logic [NUM_CLIENTS-1:0]   r_data_rd_en;
  logic [NUM_CLIENTS-1:0]   r_addr_rd_en;
  logic [ADDR_WIDTH-1:0]    r_app_addr;
  logic [255:0]             r_wdf_data;
  logic                     r_app_en;
  logic                     r_wdf_wren;
  logic [31:0]              r_wcnt [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0]   w_elig;
  logic                     w_found;
  logic [GW-1:0]            w_pick;
  int                       w_idx;
  logic [ADDR_WIDTH-1:0]    w_addr_g;
  logic [127:0]             w_data_g;
  logic                     w_stay;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_elig[i] = (addr_rd_size[i*ASIZE_WIDTH +: ASIZE_WIDTH] != '0) &&
                  (data_rd_size[i*SIZE_WIDTH +: SIZE_WIDTH] >= SIZE_WIDTH'(2));
    end
  end

  // Scan downward so the closest eligible client after r_last is the final (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NUM_CLIENTS;
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = GW'(w_idx);
      end
    end
  end

  assign w_addr_g = addr_rd_data[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_data_g = data_rd_data[int'(r_grant)*128 +: 128];
  assign w_stay   = ((9'(r_burst) + 9'd1) < 9'(MAX_BURST)) && w_elig[r_grant] && cal_complete;

  always_ff @(posedge clk_ram) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last       <= GW'(NUM_CLIENTS - 1);
      r_burst      <= '0;
      r_data_rd_en <= '0;
      r_addr_rd_en <= '0;
      r_app_addr   <= '0;
      r_wdf_data   <= '0;
      r_app_en     <= 1'b0;
      r_wdf_wren   <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) r_wcnt[i] <= WRITE_COUNT_RESET;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cal_complete && w_found) begin
            r_grant      <= w_pick;
            r_burst      <= '0;
            r_addr_rd_en <= NUM_CLIENTS'(1) << w_pick;
            r_data_rd_en <= NUM_CLIENTS'(1) << w_pick;
            r_state      <= S_POP0;
          end
        end
        S_POP0: begin
          r_addr_rd_en <= '0;
          r_state      <= S_POP1;
        end
        S_POP1: begin
          r_data_rd_en       <= '0;
          r_app_addr         <= w_addr_g;
          r_wdf_data[127:0]  <= w_data_g;
          r_state            <= S_CAPT;
        end
        S_CAPT: begin
          r_wdf_data[255:128] <= w_data_g;
          r_app_en            <= 1'b1;
          r_wdf_wren          <= 1'b1;
          r_state             <= S_ISSUE;
        end
        S_ISSUE: begin
          if (r_app_en && app_rdy) r_app_en <= 1'b0;
          if (r_wdf_wren && app_wdf_rdy) r_wdf_wren <= 1'b0;
          // Both halves were accepted on earlier edges: this is the exit cycle.
          if (!r_app_en && !r_wdf_wren) begin
            r_wcnt[r_grant] <= r_wcnt[r_grant] + 32'd1;
            if (w_stay) begin
              r_burst      <= r_burst + 8'd1;
              r_addr_rd_en <= NUM_CLIENTS'(1) << r_grant;
              r_data_rd_en <= NUM_CLIENTS'(1) << r_grant;
              r_state      <= S_POP0;
            end else begin
              r_last  <= r_grant;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    write_count = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) write_count[i*32 +: 32] = r_wcnt[i];
  end

  assign data_rd_en   = r_data_rd_en;
  assign addr_rd_en   = r_addr_rd_en;
  assign app_addr     = r_app_addr;
  assign app_cmd      = 3'b000;
  assign app_en       = r_app_en;
  assign app_wdf_data = r_wdf_data;
  assign app_wdf_wren = r_wdf_wren;
  assign app_wdf_end  = r_wdf_wren;
  assign app_wdf_mask = 32'h0;
  assign app_ref_req  = 1'b0;
  assign app_sr_req   = 1'b0;
  assign app_zq_req   = 1'b0;
  assign busy         = (r_state != S_IDLE);
  assign grant_id     = r_grant;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb/tb_mem_write_arbiter.sv - randomized self-checking bench for mem_write_arbiter
// Client FIFOs are queues; expected grant order is derived from the round-robin/burst rules.
module tb_mem_write_arbiter;
  localparam int NC  = 4;
  localparam int AW  = 29;
  localparam int SW  = 10;
  localparam int ASW = 8;
  localparam int MB  = 8;
  localparam int GW  = 2;

  typedef struct {
    int            cl;
    logic [AW-1:0] addr;
    logic [255:0]  data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                cal = 1'b0;
  logic                app_rdy = 1'b0;
  logic                app_wdf_rdy = 1'b0;
  logic [NC-1:0]       data_rd_en, addr_rd_en;
  logic [NC*128-1:0]   data_rd_data = '0;
  logic [NC*SW-1:0]    data_rd_size = '0;
  logic [NC*AW-1:0]    addr_rd_data = '0;
  logic [NC*ASW-1:0]   addr_rd_size = '0;
  logic [AW-1:0]       app_addr;
  logic [2:0]          app_cmd;
  logic                app_en, app_wdf_end, app_wdf_wren;
  logic [255:0]        app_wdf_data;
  logic [31:0]         app_wdf_mask;
  logic                app_ref_req, app_sr_req, app_zq_req, busy;
  logic [GW-1:0]       grant_id;
  logic [NC*32-1:0]    write_count;

  mem_write_arbiter #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                      .ASIZE_WIDTH(ASW), .MAX_BURST(MB)) dut (
    .clk_ram(clk), .rst(rst), .cal_complete(cal),
    .data_rd_en(data_rd_en), .data_rd_data(data_rd_data), .data_rd_size(data_rd_size),
    .addr_rd_en(addr_rd_en), .addr_rd_data(addr_rd_data), .addr_rd_size(addr_rd_size),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_rdy(app_wdf_rdy),
    .app_ref_req(app_ref_req), .app_sr_req(app_sr_req), .app_zq_req(app_zq_req),
    .busy(busy), .grant_id(grant_id), .write_count(write_count)
  );

  // Single-client instance whose counter resets just below the wrap point.
  logic          cal_w = 1'b0;
  logic          w_drd, w_ard, w_en, w_wdf_end, w_wren, w_ref, w_sr, w_zq, w_busy, w_gid;
  logic [AW-1:0] w_addr;
  logic [2:0]    w_cmd;
  logic [255:0]  w_wdata;
  logic [31:0]   w_mask, w_cnt;

  mem_write_arbiter #(.NUM_CLIENTS(1), .WRITE_COUNT_RESET(32'hFFFF_FFFF)) u_wrap (
    .clk_ram(clk), .rst(rst), .cal_complete(cal_w),
    .data_rd_en(w_drd), .data_rd_data(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677),
    .data_rd_size(10'd9), .addr_rd_en(w_ard), .addr_rd_data(29'h0000_5A5), .addr_rd_size(8'd5),
    .app_addr(w_addr), .app_cmd(w_cmd), .app_en(w_en), .app_rdy(1'b1),
    .app_wdf_data(w_wdata), .app_wdf_end(w_wdf_end), .app_wdf_mask(w_mask),
    .app_wdf_wren(w_wren), .app_wdf_rdy(1'b1),
    .app_ref_req(w_ref), .app_sr_req(w_sr), .app_zq_req(w_zq),
    .busy(w_busy), .grant_id(w_gid), .write_count(w_cnt)
  );

  logic [AW-1:0] aq [NC][$];
  logic [127:0]  dq [NC][$];
  wr_t           ex_q [NC][$];
  wr_t           log_q [$];
  wr_t           eq [$];
  int            pop_a [NC];
  int            viol = 0;
  int            total = 0;
  int            bad = 0;
  logic [31:0]   exp_cnt [NC];
  int            last_g = NC - 1;
  bit            rand_rdy = 1'b0;

  // Client FIFO model: one-cycle read latency, fill counts updated at the pop edge.
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (addr_rd_en[i]) begin
        pop_a[i]++;
        if (aq[i].size() == 0) viol++;
        else addr_rd_data[i*AW +: AW] <= aq[i].pop_front();
      end
      if (data_rd_en[i]) begin
        if (dq[i].size() == 0) viol++;
        else data_rd_data[i*128 +: 128] <= dq[i].pop_front();
      end
      addr_rd_size[i*ASW +: ASW] <= ASW'(aq[i].size());
      data_rd_size[i*SW +: SW]   <= SW'(dq[i].size());
    end
  end

  // Monitor: logs completed writes and counts protocol violations.
  logic          got_cmd = 1'b0, got_dat = 1'b0, p_en = 1'b0, p_wr = 1'b0;
  logic [AW-1:0] m_addr, p_addr;
  logic [255:0]  m_data, p_data;
  always @(negedge clk) begin
    if (rst) begin
      got_cmd = 1'b0; got_dat = 1'b0; p_en = 1'b0; p_wr = 1'b0;
    end else begin
      if ($countones(data_rd_en) > 1 || $countones(addr_rd_en) > 1) viol++;
      for (int i = 0; i < NC; i++)
        if (addr_rd_en[i] && (addr_rd_size[i*ASW +: ASW] == 0 || data_rd_size[i*SW +: SW] < 2)) viol++;
      if (p_en && !(app_en && app_addr == p_addr)) viol++;
      if (p_wr && !(app_wdf_wren && app_wdf_data == p_data)) viol++;
      p_en = app_en && !app_rdy;  p_addr = app_addr;
      p_wr = app_wdf_wren && !app_wdf_rdy;  p_data = app_wdf_data;
      if (app_en && app_rdy) begin got_cmd = 1'b1; m_addr = app_addr; end
      if (app_wdf_wren && app_wdf_rdy) begin got_dat = 1'b1; m_data = app_wdf_data; end
      if (got_cmd && got_dat) begin
        log_q.push_back('{int'(grant_id), m_addr, m_data});
        got_cmd = 1'b0; got_dat = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) begin
      app_rdy     = 1'($urandom_range(0, 1));
      app_wdf_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_wr(input int c, input logic [AW-1:0] a, input logic [127:0] d0, input logic [127:0] d1);
    aq[c].push_back(a); dq[c].push_back(d0); dq[c].push_back(d1);
    ex_q[c].push_back('{c, a, {d1, d0}});
  endtask

  task automatic push_rand(input int c);
    push_wr(c, AW'($urandom), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic clear_all();
    for (int c = 0; c < NC; c++) begin aq[c].delete(); dq[c].delete(); ex_q[c].delete(); end
    log_q.delete();
  endtask

  // Reference: round-robin from last grant, at most MB writes per grant, all queued work visible.
  task automatic predict();
    int rem [NC];
    int g, c, n, left;
    eq.delete();
    left = 0;
    for (int i = 0; i < NC; i++) begin rem[i] = ex_q[i].size(); left += rem[i]; end
    g = last_g;
    while (left > 0) begin
      c = g;
      for (int k = 1; k <= NC; k++) if (rem[(g + k) % NC] > 0) begin c = (g + k) % NC; break; end
      n = (rem[c] < MB) ? rem[c] : MB;
      for (int j = 0; j < n; j++) eq.push_back(ex_q[c].pop_front());
      rem[c] -= n; left -= n; exp_cnt[c] += 32'(n);
      g = c;
    end
    last_g = g;
  endtask

  task automatic test_reset();
    rst = 1'b1; cal = 1'b0; cal_w = 1'b0; rand_rdy = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    tick(3);
    total++;
    if ({data_rd_en, addr_rd_en, app_en, app_wdf_wren, busy} !== '0) begin
      bad++; $display("FAIL reset_ctl: got %b want 0", {data_rd_en, addr_rd_en, app_en, app_wdf_wren, busy});
    end
    total++;
    if (app_addr !== '0 || app_wdf_data !== '0 || grant_id !== '0) begin
      bad++; $display("FAIL reset_data: addr %h data %h grant %0d want 0", app_addr, app_wdf_data, grant_id);
    end
    total++;
    if (write_count !== '0) begin bad++; $display("FAIL reset_count: got %h want 0", write_count); end
    total++;
    if (app_cmd !== 3'b000 || app_wdf_mask !== 32'h0 || {app_ref_req, app_sr_req, app_zq_req} !== 3'b000 || app_wdf_end !== app_wdf_wren) begin
      bad++; $display("FAIL reset_ties: cmd %b mask %h reqs %b", app_cmd, app_wdf_mask, {app_ref_req, app_sr_req, app_zq_req});
    end
    total++;
    if (w_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_wrapcnt: got %h want ffffffff", w_cnt); end
    rst = 1'b0;
    for (int c = 0; c < NC; c++) exp_cnt[c] = '0;
    last_g = NC - 1;
  endtask

  task automatic test_cal_gate();
    logic [127:0] w0, w1;
    int p0;
    w0 = {$urandom, $urandom, $urandom, $urandom};
    w1 = {$urandom, $urandom, $urandom, $urandom};
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    p0 = pop_a[0];
    push_wr(0, 29'h0000100, w0, w1);
    tick(20);
    total++;
    if (pop_a[0] != p0 || log_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL cal_gate: pops %0d writes %0d busy %b want 0 0 0", pop_a[0] - p0, log_q.size(), busy);
    end
    cal = 1'b1;
    predict();
    for (int t = 0; t < 100 && log_q.size() < 1; t++) tick(1);
    tick(3);
    total++;
    if (log_q.size() != 1) begin bad++; $display("FAIL cal_writes: got %0d want 1", log_q.size()); end
    else begin
      total++;
      if (log_q[0].cl != 0 || log_q[0].addr !== 29'h0000100 || log_q[0].data !== {w1, w0}) begin
        bad++; $display("FAIL cal_content: client %0d addr %h data %h want 0 100 %h", log_q[0].cl, log_q[0].addr, log_q[0].data, {w1, w0});
      end
    end
    total++;
    if (write_count[31:0] !== 32'd1) begin bad++; $display("FAIL cal_count: got %0d want 1", write_count[31:0]); end
    log_q.delete();
  endtask

  task automatic test_round_robin();
    int first;
    int nbad;
    for (int c = 0; c < NC; c++) for (int j = 0; j < 20; j++) push_rand(c);
    predict();
    rand_rdy = 1'b1;
    for (int t = 0; t < 4000 && log_q.size() < eq.size(); t++) tick(1);
    rand_rdy = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    tick(10);
    total++;
    if (log_q.size() != eq.size()) begin bad++; $display("FAIL rr_len: got %0d want %0d", log_q.size(), eq.size()); end
    first = -1;
    for (int i = 0; i < eq.size() && i < log_q.size(); i++)
      if (first < 0 && (log_q[i].cl != eq[i].cl || log_q[i].addr !== eq[i].addr || log_q[i].data !== eq[i].data)) first = i;
    total++;
    if (first >= 0) begin
      bad++; $display("FAIL rr_order: entry %0d client %0d addr %h want client %0d addr %h", first, log_q[first].cl, log_q[first].addr, eq[first].cl, eq[first].addr);
    end
    nbad = 0;
    for (int c = 0; c < NC; c++) if (write_count[c*32 +: 32] !== exp_cnt[c]) nbad++;
    total++;
    if (nbad != 0) begin bad++; $display("FAIL rr_counts: got %h, %0d clients wrong", write_count, nbad); end
    total++;
    if (viol != 0 || busy !== 1'b0) begin bad++; $display("FAIL rr_protocol: violations %0d busy %b want 0 0", viol, busy); end
    log_q.delete();
  endtask

  task automatic test_handshake(input bit cmd_late);
    int hold_bad;
    app_rdy = cmd_late ? 1'b0 : 1'b1;
    app_wdf_rdy = cmd_late ? 1'b1 : 1'b0;
    push_rand(cmd_late ? 2 : 3);
    predict();
    for (int t = 0; t < 50 && !(app_en && app_wdf_wren); t++) tick(1);
    tick(1);
    hold_bad = 0;
    for (int t = 0; t < 10; t++) begin
      if (cmd_late && !(app_en === 1'b1 && app_wdf_wren === 1'b0 && app_addr === eq[0].addr)) hold_bad++;
      if (!cmd_late && !(app_wdf_wren === 1'b1 && app_en === 1'b0 && app_wdf_data === eq[0].data)) hold_bad++;
      tick(1);
    end
    total++;
    if (hold_bad != 0) begin bad++; $display("FAIL hs_hold_%0d: %0d bad cycles want 0", cmd_late, hold_bad); end
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int t = 0; t < 50 && log_q.size() < 1; t++) tick(1);
    tick(3);
    total++;
    if (log_q.size() != 1 || log_q[0].cl != eq[0].cl || log_q[0].addr !== eq[0].addr || log_q[0].data !== eq[0].data) begin
      bad++; $display("FAIL hs_write_%0d: writes %0d want 1 matching client %0d", cmd_late, log_q.size(), eq[0].cl);
    end
    total++;
    if (write_count[eq[0].cl*32 +: 32] !== exp_cnt[eq[0].cl]) begin
      bad++; $display("FAIL hs_count_%0d: got %0d want %0d", cmd_late, write_count[eq[0].cl*32 +: 32], exp_cnt[eq[0].cl]);
    end
    log_q.delete();
  endtask

  task automatic test_ineligible();
    int p1;
    logic [AW-1:0] a0;
    logic [127:0]  d0, d1;
    a0 = AW'($urandom); d0 = {$urandom, $urandom, $urandom, $urandom}; d1 = {$urandom, $urandom, $urandom, $urandom};
    rand_rdy = 1'b1;
    p1 = pop_a[1];
    aq[1].push_back(a0); aq[1].push_back(AW'($urandom)); aq[1].push_back(AW'($urandom));
    dq[1].push_back(d0);
    tick(30);
    total++;
    if (pop_a[1] != p1 || log_q.size() != 0) begin
      bad++; $display("FAIL inelig_idle: pops %0d writes %0d want 0 0", pop_a[1] - p1, log_q.size());
    end
    dq[1].push_back(d1);
    for (int t = 0; t < 200 && log_q.size() < 1; t++) tick(1);
    tick(30);
    total++;
    if (log_q.size() != 1 || log_q[0].cl != 1 || log_q[0].addr !== a0 || log_q[0].data !== {d1, d0}) begin
      bad++; $display("FAIL inelig_write: writes %0d want 1 to client 1 addr %h", log_q.size(), a0);
    end
    total++;
    if (pop_a[1] - p1 != 1 || aq[1].size() != 2 || write_count[63:32] !== exp_cnt[1] + 32'd1) begin
      bad++; $display("FAIL inelig_pops: pops %0d left %0d count %0d want 1 2 %0d", pop_a[1] - p1, aq[1].size(), write_count[63:32], exp_cnt[1] + 32'd1);
    end
    exp_cnt[1] += 32'd1; last_g = 1;
    rand_rdy = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    clear_all();
    tick(3);
  endtask

  task automatic test_reset_mid();
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    push_rand(3);
    for (int t = 0; t < 50 && !app_en; t++) tick(1);
    total++;
    if (app_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rmid_issue: app_en %b busy %b want 1 1", app_en, busy); end
    rst = 1'b1;
    tick(1);
    total++;
    if ({data_rd_en, addr_rd_en, app_en, app_wdf_wren, busy} !== '0 || app_addr !== '0 || app_wdf_data !== '0 || grant_id !== '0 || write_count !== '0) begin
      bad++; $display("FAIL rmid_reset: ctl %b addr %h grant %0d count %h want all 0", {data_rd_en, addr_rd_en, app_en, app_wdf_wren, busy}, app_addr, grant_id, write_count);
    end
    rst = 1'b0;
    clear_all();
    for (int c = 0; c < NC; c++) exp_cnt[c] = '0;
    last_g = NC - 1;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    tick(2);
    push_rand(2); push_rand(0);
    predict();
    for (int t = 0; t < 100 && log_q.size() < 2; t++) tick(1);
    tick(3);
    total++;
    if (log_q.size() != 2 || log_q[0].cl != 0 || log_q[1].cl != 2 || log_q[0].addr !== eq[0].addr || log_q[1].addr !== eq[1].addr) begin
      bad++; $display("FAIL rmid_regrant: writes %0d first client %0d want 2 writes starting at client 0", log_q.size(), (log_q.size() > 0) ? log_q[0].cl : -1);
    end
    total++;
    if (write_count !== {32'd0, exp_cnt[2], 32'd0, exp_cnt[0]} || viol != 0) begin
      bad++; $display("FAIL rmid_counts: got %h violations %0d want client0=1 client2=1", write_count, viol);
    end
    log_q.delete();
  endtask

  task automatic test_wrap();
    int seen;
    seen = 0;
    cal_w = 1'b1;
    for (int t = 0; t < 100 && seen < 2; t++) begin
      tick(1);
      if (w_ard) begin
        seen++;
        if (seen == 2) begin
          cal_w = 1'b0;
          total++;
          if (w_cnt !== 32'h0) begin bad++; $display("FAIL wrap_first: got %h want 0", w_cnt); end
        end
      end
    end
    for (int t = 0; t < 100 && w_busy; t++) tick(1);
    tick(20);
    total++;
    if (seen != 2 || w_cnt !== 32'h0000_0001 || w_busy !== 1'b0) begin
      bad++; $display("FAIL wrap_final: pops %0d count %h busy %b want 2 00000001 0", seen, w_cnt, w_busy);
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) pop_a[c] = 0;
    test_reset();
    test_cal_gate();
    test_round_robin();
    test_handshake(1'b1);
    test_handshake(1'b0);
    test_ineligible();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_write_arbiter.md
Name: mem_write_arbiter

Overview:
N-client write arbiter between logic-analyzer and SATA capture FIFOs and the DDR3 controller application interface, in the clk_ram domain.
- Generalises the current fixed two-client (LA0/LA1) arbitration to NUM_CLIENTS ports.
- Round-robin fairness with a bounded per-grant burst.
- Gated by calibration-complete; per-client write counters.
- Each address FIFO entry describes one 256-bit write and consumes two 128-bit data FIFO words.

Parameters:
NUM_CLIENTS, 2, number of client FIFO pairs (1..16)
ADDR_WIDTH, 29, controller app_addr width
SIZE_WIDTH, 10, width of each client data FIFO fill count
ASIZE_WIDTH, 8, width of each client address FIFO fill count
MAX_BURST, 8, max consecutive writes issued for one client per grant (1..255)

Ports:
clk_ram  in  1  controller UI clock; all logic on rising edge
rst  in  1  synchronous active-high reset
cal_complete  in  1  DDR calibration done; no new grant while low
data_rd_en  out  NUM_CLIENTS  per-client data FIFO pop
data_rd_data  in  NUM_CLIENTS*128  client i at [i*128 +: 128]; valid 1 cycle after pop
data_rd_size  in  NUM_CLIENTS*SIZE_WIDTH  data FIFO fill counts
addr_rd_en  out  NUM_CLIENTS  per-client address FIFO pop
addr_rd_data  in  NUM_CLIENTS*ADDR_WIDTH  valid 1 cycle after pop
addr_rd_size  in  NUM_CLIENTS*ASIZE_WIDTH  address FIFO fill counts
app_addr  out  ADDR_WIDTH  controller address
app_cmd  out  3  always 3'b000 (write)
app_en  out  1  command valid
app_rdy  in  1  command accept
app_wdf_data  out  256  write data
app_wdf_end  out  1  equals app_wdf_wren
app_wdf_mask  out  32  always 0
app_wdf_wren  out  1  data valid
app_wdf_rdy  in  1  data accept
app_ref_req, app_sr_req, app_zq_req  out  1 each  tied 0
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_CLIENTS) min 1  client currently granted
write_count  out  NUM_CLIENTS*32  per-client completed writes; wraps modulo 2^32

Behaviour:
- Reset values: all rd_en, app_en, app_wdf_wren, busy = 0; app_addr, app_wdf_data, grant_id, write_count = 0.
- Eligible(i): addr_rd_size[i] >= 1 and data_rd_size[i] >= 2. Fill counts reflect a pop by the second cycle after it.
- FSM states: IDLE, POP0, POP1, CAPT, ISSUE.
- IDLE:
  - Requires cal_complete = 1 and at least one eligible client.
  - Grant goes to the first eligible client scanning upward from (last_grant+1) mod NUM_CLIENTS. After reset, last_grant = NUM_CLIENTS-1, so client 0 has first priority.
  - Load grant_id; burst_cnt = 0; go to POP0.
- POP0: addr_rd_en[g] = 1 and data_rd_en[g] = 1 for one cycle.
- POP1: data_rd_en[g] = 1; capture app_addr <= addr_rd_data[g] and app_wdf_data[127:0] <= data word.
- CAPT: capture app_wdf_data[255:128] <= second data word; assert app_en and app_wdf_wren next cycle; go to ISSUE.
- ISSUE:
  - Command accepted on app_en & app_rdy: drop app_en.
  - Data accepted on app_wdf_wren & app_wdf_rdy: drop app_wdf_wren.
  - Command and data may be accepted in the same or different cycles, in either order. Each stays asserted, with stable value, until its own accept.
  - Leave ISSUE the cycle after both are accepted: write_count[g] += 1, burst_cnt += 1.
  - Stay on client: if burst_cnt < MAX_BURST and Eligible(g) and cal_complete, go to POP0 for the same client.
  - Otherwise: last_grant = g, go to IDLE.
- Pops: at most one client's rd_en is high in any cycle; rd_en is never asserted to an ineligible client. Exactly 1 address pop and 2 data pops per issued write.
- cal_complete falling mid-transaction does not abort. The current write completes; no further grant.
- rst during any state: return to IDLE next cycle, outputs to reset values, and the in-flight write is discarded (whole-system reset).
- Minimum 5 cycles per write (POP0, POP1, CAPT, ISSUE, exit); peak throughput is not a goal of this block.

Test Plan:
1. cal_complete = 0; client 0 has addr_size 1, data_size 2 -> no rd_en, app_en stays 0. Raise cal_complete -> exactly one write with app_addr = 0x0000100 and wdf_data = {word1, word0}; write_count[0] = 1.
2. NUM_CLIENTS = 4, all clients loaded with 20 writes, MAX_BURST = 8 -> grants in order 0,1,2,3,0,... with 8 writes per grant, then 4. Final counts 20/20/20/20.
3. app_rdy held low 10 cycles while app_wdf_rdy = 1 -> wdf accepted first, app_en held with stable address, completes on app_rdy. Then reverse the order -> same result.
4. Client 1 has data_size 1, addr_size 3 -> never granted. Push one more data word -> granted, one write issued.
5. Assert rst in ISSUE with app_en = 1 -> next cycle all outputs at reset values, write_count = 0. The next grant goes to client 0.
6. Wrap test: preload write_count[0] near 0xFFFF_FFFF via forced reset state, issue 2 writes -> count wraps to 0x0000_0001.
